regfile_scoreboard: RTL and testbench

- Hazard scoreboard that sequences access to the 32x32 register file in the pipelined MIPS core.
- Tracks which destination registers have writes in flight between issue and writeback.
- Stalls issue on RAW/WAW hazards and caps outstanding writes.
- Sits beside decode; its issue_ready gates the IF/ID hold and ID/EX bubble insertion.

---
 rtl/regfile_scoreboard.sv | 87 ++++++++
 tb/tb_regfile_scoreboard.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Register-file hazard scoreboard: tracks in-flight destination writes and gates issue on RAW/WAW/capacity.
// Optional macro SCOREBOARD_WB_BYPASS_EN lets a same-cycle writeback clear hide the pending bit from the hazard check.
module regfile_scoreboard #(
   parameter int NUM_REGS     = 32,
   parameter int ADDR_W       = 5,
   parameter int MAX_INFLIGHT = 4,
   parameter int CNT_W        = 16,
   localparam int INF_W       = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                issue_valid,
   input  logic [ADDR_W-1:0]   issue_rs,
   input  logic [ADDR_W-1:0]   issue_rt,
   input  logic                issue_uses_rs,
   input  logic                issue_uses_rt,
   input  logic                issue_writes,
   input  logic [ADDR_W-1:0]   issue_dst,
   output logic                issue_ready,
   input  logic                wb_valid,
   input  logic [ADDR_W-1:0]   wb_dst,
   input  logic                flush,
   output logic [NUM_REGS-1:0] pending,
   output logic [INF_W-1:0]    inflight,
   output logic [CNT_W-1:0]    stall_count,
   output logic                err
);

   localparam logic [INF_W-1:0] MAX_CNT = INF_W'(MAX_INFLIGHT);
   localparam logic [NUM_REGS-1:0] ONE  = {{(NUM_REGS-1){1'b0}}, 1'b1};

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      sat_inc = (&v) ? v : v + CNT_W'(1);
   endfunction

   logic                wb_clr;
   logic                do_set;
   logic                full;
   logic                hazard;
   logic [NUM_REGS-1:0] clr_mask;
   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] eff_pend;

   always_comb begin
      wb_clr   = wb_valid && (wb_dst != '0) && pending[wb_dst];
      clr_mask = wb_clr ? (ONE << wb_dst) : '0;
`ifdef SCOREBOARD_WB_BYPASS_EN
      // A register retiring this cycle is readable/rewritable, mirroring write-then-read regfile timing.
      eff_pend = pending & ~clr_mask;
      full     = (inflight == MAX_CNT) && !wb_clr;
`else
      eff_pend = pending;
      full     = (inflight == MAX_CNT);
`endif
      hazard = (issue_uses_rs && (issue_rs  != '0) && eff_pend[issue_rs])
             | (issue_uses_rt && (issue_rt  != '0) && eff_pend[issue_rt])
             | (issue_writes  && (issue_dst != '0) && eff_pend[issue_dst])
             | (issue_writes  && (issue_dst != '0) && full)
             | flush;
      issue_ready = reset && !hazard;
      do_set   = issue_valid && issue_ready && issue_writes && (issue_dst != '0);
      set_mask = do_set ? (ONE << issue_dst) : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending     <= '0;
         inflight    <= '0;
         stall_count <= '0;
         err         <= 1'b0;
      end else begin
         if (issue_valid && !issue_ready)
            stall_count <= sat_inc(stall_count);
         if (wb_valid && !wb_clr)
            err <= 1'b1;
         if (flush) begin
            pending  <= '0;
            inflight <= '0;
         end else begin
            // Set wins over clear so a bypassed same-register reissue keeps its bit.
            pending  <= (pending & ~clr_mask) | set_mask;
            inflight <= inflight + INF_W'(do_set) - INF_W'(wb_clr);
         end
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard (CNT_W=4 so stall-counter saturation is reachable).
module tb_regfile_scoreboard;

   logic        clk = 1'b0;
   logic        reset;
   logic        issue_valid, issue_uses_rs, issue_uses_rt, issue_writes;
   logic [4:0]  issue_rs, issue_rt, issue_dst, wb_dst;
   logic        issue_ready, wb_valid, flush, err;
   logic [31:0] pending;
   logic [2:0]  inflight;
   logic [3:0]  stall_count;

   int checks = 0;
   int errors = 0;

   regfile_scoreboard #(.NUM_REGS(32), .ADDR_W(5), .MAX_INFLIGHT(4), .CNT_W(4)) dut (
      .clk(clk), .reset(reset),
      .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
      .issue_uses_rs(issue_uses_rs), .issue_uses_rt(issue_uses_rt),
      .issue_writes(issue_writes), .issue_dst(issue_dst), .issue_ready(issue_ready),
      .wb_valid(wb_valid), .wb_dst(wb_dst), .flush(flush),
      .pending(pending), .inflight(inflight), .stall_count(stall_count), .err(err)
   );

   always #5 clk = ~clk;

   task automatic idle();
      issue_valid = 0; issue_uses_rs = 0; issue_uses_rt = 0; issue_writes = 0;
      issue_rs = 0; issue_rt = 0; issue_dst = 0; wb_valid = 0; wb_dst = 0; flush = 0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      step();
      reset = 0; idle(); #1; reset = 1; #1;
   endtask

   task automatic issue_wr(input logic [4:0] d);
      idle(); issue_valid = 1; issue_writes = 1; issue_dst = d;
   endtask

   task automatic test_reset();
      reset = 0; idle(); issue_valid = 1;
      step(); step();
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", issue_ready); end
      checks++; if (pending !== 32'h0 || inflight !== 3'd0) begin errors++; $display("FAIL reset_state pending %h inflight %0d want 0/0", pending, inflight); end
      checks++; if (stall_count !== 4'd0 || err !== 1'b0) begin errors++; $display("FAIL reset_cnt stall %0d err %b want 0/0", stall_count, err); end
      idle(); reset = 1; #1;
   endtask

   task automatic test_basic();
      do_reset();
      issue_wr(5); #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL basic_issue ready %b want 1", issue_ready); end
      step();
      checks++; if (pending !== 32'h20 || inflight !== 3'd1) begin errors++; $display("FAIL basic_pend pending %h inflight %0d want 20/1", pending, inflight); end
      idle(); issue_valid = 1; issue_uses_rs = 1; issue_rs = 5; #1;
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL basic_raw ready %b want 0", issue_ready); end
      step(); step(); step();
      checks++; if (stall_count !== 4'd3) begin errors++; $display("FAIL basic_stall got %0d want 3", stall_count); end
      idle(); wb_valid = 1; wb_dst = 5; step();
      checks++; if (pending !== 32'h0 || inflight !== 3'd0) begin errors++; $display("FAIL basic_wb pending %h inflight %0d want 0/0", pending, inflight); end
      idle(); issue_valid = 1; issue_uses_rs = 1; issue_rs = 5; #1;
      checks++; if (issue_ready !== 1'b1 || stall_count !== 4'd3) begin errors++; $display("FAIL basic_release ready %b stall %0d want 1/3", issue_ready, stall_count); end
      idle();
   endtask

   task automatic test_dst0();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         issue_wr(0); #1;
         checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL dst0_ready cycle %0d got %b want 1", i, issue_ready); end
         step();
      end
      checks++; if (pending !== 32'h0 || inflight !== 3'd0) begin errors++; $display("FAIL dst0_state pending %h inflight %0d want 0/0", pending, inflight); end
      idle();
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int r = 1; r <= 4; r++) begin issue_wr(5'(r)); step(); end
      checks++; if (pending !== 32'h1E || inflight !== 3'd4) begin errors++; $display("FAIL b2b_full pending %h inflight %0d want 1e/4", pending, inflight); end
      issue_wr(6); #1;
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL b2b_cap ready %b want 0", issue_ready); end
      idle(); issue_valid = 1; issue_uses_rs = 1; issue_rs = 7; #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL b2b_nowrite ready %b want 1", issue_ready); end
      issue_uses_rt = 1; issue_rt = 2; #1;
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL b2b_rt_raw ready %b want 0", issue_ready); end
      issue_wr(6); wb_valid = 1; wb_dst = 1; #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL b2b_full_wb ready %b want 1", issue_ready); end
      step();
      checks++; if (pending !== 32'h5C || inflight !== 3'd4) begin errors++; $display("FAIL b2b_full_wb_st pending %h inflight %0d want 5c/4", pending, inflight); end
      idle(); wb_valid = 1; wb_dst = 6; step();
`else
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_wb ready %b want 0", issue_ready); end
      step();
      checks++; if (pending !== 32'h1C || inflight !== 3'd3) begin errors++; $display("FAIL b2b_full_wb_st pending %h inflight %0d want 1c/3", pending, inflight); end
`endif
      issue_wr(6); wb_valid = 1; wb_dst = 2; #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL b2b_swap ready %b want 1", issue_ready); end
      step();
      checks++; if (pending !== 32'h58 || inflight !== 3'd3) begin errors++; $display("FAIL b2b_swap_st pending %h inflight %0d want 58/3", pending, inflight); end
      idle();
   endtask

   task automatic test_flush();
      do_reset();
      issue_wr(3); step(); issue_wr(7); step();
      checks++; if (pending !== 32'h88) begin errors++; $display("FAIL flush_pre pending %h want 88", pending); end
      issue_wr(9); flush = 1; wb_valid = 1; wb_dst = 3; #1;
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL flush_ready ready %b want 0", issue_ready); end
      step();
      checks++; if (pending !== 32'h0 || inflight !== 3'd0 || err !== 1'b0) begin errors++; $display("FAIL flush_state pending %h inflight %0d err %b want 0/0/0", pending, inflight, err); end
      checks++; if (stall_count !== 4'd1) begin errors++; $display("FAIL flush_stall got %0d want 1", stall_count); end
      idle();
   endtask

   task automatic test_err_reset();
      do_reset();
      idle(); wb_valid = 1; wb_dst = 12; step();
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", err); end
      idle(); step(); step();
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err); end
      issue_wr(2); step(); idle();
      checks++; if (pending !== 32'h4) begin errors++; $display("FAIL err_pre pending %h want 4", pending); end
      #2 reset = 0; #1;
      checks++; if (pending !== 32'h0 || err !== 1'b0 || inflight !== 3'd0) begin errors++; $display("FAIL async_reset pending %h err %b inflight %0d want 0/0/0", pending, err, inflight); end
      reset = 1; #1;
   endtask

   task automatic test_wb_zero();
      do_reset();
      idle(); wb_valid = 1; wb_dst = 0; step();
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL wb_zero_err got %b want 1", err); end
      idle();
   endtask

   task automatic test_saturate();
      do_reset();
      issue_wr(1); step();
      idle(); issue_valid = 1; issue_uses_rs = 1; issue_rs = 1;
      for (int i = 0; i < 21; i++) step();
      checks++; if (stall_count !== 4'd15) begin errors++; $display("FAIL stall_sat got %0d want 15", stall_count); end
      idle();
   endtask

   task automatic test_bypass();
      do_reset();
      issue_wr(8); step();
      idle(); issue_valid = 1; issue_uses_rs = 1; issue_rs = 8;
      issue_writes = 1; issue_dst = 8; wb_valid = 1; wb_dst = 8; #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL bypass_ready got %b want 1", issue_ready); end
      step();
      checks++; if (pending !== 32'h100 || inflight !== 3'd1) begin errors++; $display("FAIL bypass_state pending %h inflight %0d want 100/1", pending, inflight); end
`else
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL bypass_ready got %b want 0", issue_ready); end
      step();
      checks++; if (pending !== 32'h0 || inflight !== 3'd0) begin errors++; $display("FAIL bypass_state pending %h inflight %0d want 0/0", pending, inflight); end
`endif
      idle();
   endtask

   initial begin
      idle(); reset = 0;
      test_reset();
      test_basic();
      test_dst0();
      test_back_to_back();
      test_flush();
      test_err_reset();
      test_wb_zero();
      test_saturate();
      test_bypass();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
